hazard_controller: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage MIPS-32 core (IF, ID, EX, MEM, WB). It sits beside the decode stage and takes the decoded fields of the instruction in ID. It tracks in-flight destination registers for EX, MEM and WB, and from them drives:
- stall and bubble signals,
- forwarding selects for the two source operands,
- flush on jumps and taken branches,
- the HALT drain sequence.

---
 rtl/mips_ctrl_pkg.sv | 89 ++++++++
 rtl/hazard_scoreboard.sv | 55 +++++
 rtl/hazard_controller.sv | 151 +++++++++++++++
 tb/tb_hazard_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS-32 pipeline control blocks: opcodes, class and
// forwarding encodings, controller states, scoreboard entries and the ID decoder.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  typedef enum logic [1:0] {
    CLS_R    = 2'd0,
    CLS_J    = 2'd1,
    CLS_HALT = 2'd2,
    CLS_I    = 2'd3
  } instr_class_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2,
    FWD_WB    = 2'd3
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_DRAIN,
    ST_HALTED
  } ctrl_state_e;

  // dest of 5'd0 doubles as "no destination", so r0 never produces a match
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
    logic       is_halt;
  } sb_entry_t;

  typedef struct packed {
    instr_class_e cls;
    logic [4:0]   dest;
    logic         use_rs;
    logic         use_rt;
    logic         is_load;
    logic         is_halt;
  } decode_t;

  function automatic decode_t decode_instr(input logic [5:0] op,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd);
    decode_t d;
    d     = '0;
    d.cls = CLS_I;
    case (op)
      OP_R: begin
        d.cls    = CLS_R;
        d.dest   = rd;
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
      end
      OP_J:    d.cls = CLS_J;
      OP_HALT: begin
        d.cls     = CLS_HALT;
        d.is_halt = 1'b1;
      end
      OP_ADDI, OP_ANDI: begin
        d.dest   = rt;
        d.use_rs = 1'b1;
      end
      OP_LW: begin
        d.dest    = rt;
        d.use_rs  = 1'b1;
        d.is_load = 1'b1;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-stage (EX, MEM, WB) shift register of in-flight destinations with per-stage
// destination compare against the two ID source registers.
module hazard_scoreboard
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_en,
  input  sb_entry_t  id_entry,
  input  logic [4:0] src_a,
  input  logic [4:0] src_b,
  output logic       ex_is_load,
  output logic       wb_is_halt,
  output logic [2:0] match_a,
  output logic [2:0] match_b
);

  sb_entry_t  ex_q;
  sb_entry_t  mem_q;
  logic       wb_valid;
  logic [4:0] wb_dest;
  logic       wb_halt;

  // WB only needs what the bypass compare and the drain detector look at
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_valid <= 1'b0;
      wb_dest  <= '0;
      wb_halt  <= 1'b0;
    end else if (shift_en) begin
      wb_valid <= mem_q.valid;
      wb_dest  <= mem_q.dest;
      wb_halt  <= mem_q.is_halt;
      mem_q    <= ex_q;
      ex_q     <= id_entry;
    end
  end

  function automatic logic hit(input logic v, input logic [4:0] dest,
                               input logic [4:0] src);
    return v && (src != 5'd0) && (dest == src);
  endfunction

  assign match_a    = {hit(wb_valid, wb_dest, src_a),
                       hit(mem_q.valid, mem_q.dest, src_a),
                       hit(ex_q.valid, ex_q.dest, src_a)};
  assign match_b    = {hit(wb_valid, wb_dest, src_b),
                       hit(mem_q.valid, mem_q.dest, src_b),
                       hit(ex_q.valid, ex_q.dest, src_b)};
  assign ex_is_load = ex_q.valid && ex_q.is_load;
  assign wb_is_halt = wb_valid && wb_halt;

endmodule

// File: rtl/hazard_controller.sv
// Hazard and sequencing controller beside ID: load-use stalls, operand forwarding,
// jump/branch flushes and the HALT drain, driven by the in-flight scoreboard.
module hazard_controller
  import mips_ctrl_pkg::*;
#(
  parameter int SAT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             ex_branch_taken,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_if,
  output logic             flush_id,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [SAT_W-1:0] stall_cycles
);

  ctrl_state_e      state;
  ctrl_state_e      state_nxt;
  decode_t          dec;
  sb_entry_t        id_entry;
  sb_entry_t        push_entry;
  logic [4:0]       src_a;
  logic [4:0]       src_b;
  logic [2:0]       match_a;
  logic [2:0]       match_b;
  logic             ex_is_load;
  logic             wb_is_halt;
  logic             shift_en;
  logic             load_use;
  logic             cnt_inc;
  logic [SAT_W-1:0] cnt;
  fwd_sel_e         sel_a;
  fwd_sel_e         sel_b;

  assign dec      = decode_instr(id_opcode, id_rt, id_rd);
  assign src_a    = (id_valid && dec.use_rs) ? id_rs : 5'd0;
  assign src_b    = (id_valid && dec.use_rt) ? id_rt : 5'd0;
  assign id_entry = '{valid: id_valid, dest: dec.dest,
                      is_load: dec.is_load, is_halt: dec.is_halt};

  hazard_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en   (shift_en),
    .id_entry   (push_entry),
    .src_a      (src_a),
    .src_b      (src_b),
    .ex_is_load (ex_is_load),
    .wb_is_halt (wb_is_halt),
    .match_a    (match_a),
    .match_b    (match_b)
  );

  // A load in EX cannot forward yet, so its match falls through to older stages
  function automatic fwd_sel_e pick_fwd(input logic [2:0] m, input logic ex_load);
    if (m[0] && !ex_load) return FWD_EXMEM;
    if (m[1])             return FWD_MEMWB;
    if (m[2])             return FWD_WB;
    return FWD_RF;
  endfunction

  assign sel_a    = pick_fwd(match_a, ex_is_load);
  assign sel_b    = pick_fwd(match_b, ex_is_load);
  assign load_use = id_valid && ex_is_load && (match_a[0] || match_b[0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (cnt_inc && (cnt != {SAT_W{1'b1}}))
        cnt <= cnt + {{(SAT_W-1){1'b0}}, 1'b1};
    end
  end

  // A taken branch wins over both a load-use stall and a HALT sitting in ID
  always_comb begin
    state_nxt  = state;
    shift_en   = 1'b1;
    push_entry = id_entry;
    cnt_inc    = 1'b0;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    bubble_ex  = 1'b0;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    halted     = 1'b0;
    fwd_a      = sel_a;
    fwd_b      = sel_b;
    case (state)
      ST_RUN, ST_STALL: begin
        state_nxt = ST_RUN;
        if (ex_branch_taken) begin
          flush_if   = 1'b1;
          flush_id   = 1'b1;
          push_entry = '0;
        end else if (state == ST_RUN && load_use) begin
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          bubble_ex  = 1'b1;
          push_entry = '0;
          cnt_inc    = 1'b1;
          state_nxt  = ST_STALL;
        end else begin
          if (id_valid && dec.cls == CLS_J) flush_if = 1'b1;
          if (state == ST_RUN && id_valid && dec.is_halt) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        stall_if   = 1'b1;
        flush_if   = 1'b1;
        push_entry = '0;
        fwd_a      = FWD_RF;
        fwd_b      = FWD_RF;
        if (wb_is_halt) state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        halted   = 1'b1;
        shift_en = 1'b0;
        fwd_a    = FWD_RF;
        fwd_b    = FWD_RF;
      end
    endcase
    if (!rst_n) begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      bubble_ex = 1'b0;
      flush_if  = 1'b0;
      flush_id  = 1'b0;
      halted    = 1'b0;
      fwd_a     = FWD_RF;
      fwd_b     = FWD_RF;
    end
  end

  assign stall_cycles = rst_n ? cnt : '0;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed vector table for the multi-cycle scenarios,
// then randomized instruction streams checked against an in-flight-list model.
module tb_hazard_controller;

  localparam int SAT_W = 4;
  localparam logic [5:0] R = 6'h00, J = 6'h02, H = 6'h3f, ADDI = 6'h08, ANDI = 6'h0c;
  localparam logic [5:0] LW = 6'h23, SW = 6'h2b, BEQ = 6'h04, BNE = 6'h05;

  logic clk = 1'b0;
  logic rst_n, id_valid, ex_branch_taken;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, id_rd;
  logic stall_if, stall_id, bubble_ex, flush_if, flush_id, halted;
  logic [1:0] fwd_a, fwd_b;
  logic [SAT_W-1:0] stall_cycles;

  hazard_controller #(.SAT_W(SAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_if(flush_if), .flush_id(flush_id), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .halted(halted), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rstn; logic valid; logic [5:0] op; logic [4:0] rs, rt, rd; logic br;
    logic [13:0] exp;
  } vec_t;

  typedef struct { bit valid; int dest; bit load; bit halt; } slot_t;

  vec_t  vecs[$];
  int    applied = 0;
  int    miscompares = 0;

  // model state: flight[0] = EX, flight[1] = MEM, flight[2] = WB
  slot_t flight[$];
  bit    mHalted, mDrain, mStalled;
  int    mCount;
  bit    pReset, pShift, pHalted, pDrain, pStalled, pInc;
  slot_t pPush;

  function automatic logic [13:0] packExp(logic sif, sid, bub, fif, fid,
                                          logic [1:0] fa, fb, logic h,
                                          logic [3:0] cnt);
    return {sif, sid, bub, fif, fid, fa, fb, h, cnt};
  endfunction

  function automatic string fmt(logic [13:0] v);
    return $sformatf("sif=%b sid=%b bub=%b fif=%b fid=%b fa=%0d fb=%0d halt=%b cnt=%0d",
                     v[13], v[12], v[11], v[10], v[9], v[8:7], v[6:5], v[4], v[3:0]);
  endfunction

  function automatic void addVec(logic rstn, valid, logic [5:0] op, logic [4:0] rs, rt, rd,
                                 logic br, logic sif, sid, bub, fif, fid,
                                 logic [1:0] fa, fb, logic h, logic [3:0] cnt);
    vec_t v;
    v.rstn = rstn; v.valid = valid; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.br = br;
    v.exp = packExp(sif, sid, bub, fif, fid, fa, fb, h, cnt);
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input logic rstn, valid, input logic [5:0] op,
                               input logic [4:0] rs, rt, rd, input logic br);
    rst_n = rstn; id_valid = valid; id_opcode = op;
    id_rs = rs; id_rt = rt; id_rd = rd; ex_branch_taken = br;
  endtask

  task automatic checkOutput(input string name, input logic [13:0] expv);
    logic [13:0] act;
    @(negedge clk);
    act = {stall_if, stall_id, bubble_ex, flush_if, flush_id, fwd_a, fwd_b, halted,
           stall_cycles};
    applied++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %s, expected %s", name, fmt(act), fmt(expv));
    end
  endtask

  function automatic logic [1:0] fwdOf(int src);
    if (src == 0) return 2'd0;
    for (int d = 0; d < 3; d++)
      if (flight[d].valid && flight[d].dest == src && !(d == 0 && flight[d].load))
        return 2'(d + 1);
    return 2'd0;
  endfunction

  function automatic void modelReset();
    slot_t e;
    e = '{valid: 0, dest: 0, load: 0, halt: 0};
    flight = '{e, e, e};
    mHalted = 0; mDrain = 0; mStalled = 0; mCount = 0;
  endfunction

  // Predict this cycle's outputs from the spec rules and stage the next-state effects
  function automatic logic [13:0] predict(logic rstn, valid, logic [5:0] op,
                                          logic [4:0] rs, rt, rd, logic br);
    int dest; bit useRs, useRt, isLoad, isHalt, isJ, loadUse;
    logic [1:0] fa, fb; logic sif, sid, bub, fif, fid, h;
    slot_t none;
    none = '{valid: 0, dest: 0, load: 0, halt: 0};
    pReset = 0; pShift = 1; pHalted = mHalted; pDrain = mDrain; pStalled = 0; pInc = 0;
    pPush = none;
    {sif, sid, bub, fif, fid, h} = '0; fa = 0; fb = 0;
    if (!rstn) begin
      pReset = 1;
      return '0;
    end
    if (mHalted) begin
      pShift = 0;
      return packExp(1, 1, 0, 0, 0, 0, 0, 1, 4'(mCount));
    end
    if (mDrain) begin
      if (flight[2].valid && flight[2].halt) begin pHalted = 1; pDrain = 0; end
      return packExp(1, 0, 0, 1, 0, 0, 0, 0, 4'(mCount));
    end
    dest = 0; useRs = 0; useRt = 0; isLoad = 0; isHalt = 0; isJ = 0;
    case (op)
      R:            begin dest = rd; useRs = 1; useRt = 1; end
      ADDI, ANDI:   begin dest = rt; useRs = 1; end
      LW:           begin dest = rt; useRs = 1; isLoad = 1; end
      SW, BEQ, BNE: begin useRs = 1; useRt = 1; end
      J:            isJ = 1;
      H:            isHalt = 1;
      default: ;
    endcase
    if (valid) begin
      fa = useRs ? fwdOf(rs) : 2'd0;
      fb = useRt ? fwdOf(rt) : 2'd0;
    end
    loadUse = valid && !mStalled && flight[0].valid && flight[0].load && flight[0].dest != 0 &&
              ((useRs && rs == flight[0].dest) || (useRt && rt == flight[0].dest));
    if (br) begin
      fif = 1; fid = 1;
    end else if (loadUse) begin
      sif = 1; sid = 1; bub = 1; pStalled = 1; pInc = 1;
    end else begin
      pPush = '{valid: valid, dest: dest, load: isLoad, halt: isHalt};
      if (valid && isJ) fif = 1;
      if (valid && isHalt && !mStalled) pDrain = 1;
    end
    return packExp(sif, sid, bub, fif, fid, fa, fb, h, 4'(mCount));
  endfunction

  function automatic void commit();
    if (pReset) begin modelReset(); return; end
    if (pShift) begin
      flight.push_front(pPush);
      void'(flight.pop_back());
    end
    mHalted = pHalted; mDrain = pDrain; mStalled = pStalled;
    if (pInc && mCount < (1 << SAT_W) - 1) mCount++;
  endfunction

  initial begin
    logic [13:0] e;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic        valid, rstn, br;
    bit          hold;
    int          pick;

    applyStimulus(0, 0, R, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    //      rstn v  op    rs rt rd br  sif sid bub fif fid fa fb h cnt
    addVec(0, 0, R,    0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, LW,   1, 2, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, R,    2, 4, 3, 0,  1, 1, 1, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, R,    2, 4, 3, 0,  0, 0, 0, 0, 0, 2, 0, 0, 1);
    addVec(1, 1, R,    2, 3, 1, 0,  0, 0, 0, 0, 0, 3, 1, 0, 1);
    addVec(1, 1, R,    1, 1, 4, 0,  0, 0, 0, 0, 0, 1, 1, 0, 1);
    addVec(1, 1, R,    1, 1, 5, 0,  0, 0, 0, 0, 0, 2, 2, 0, 1);
    addVec(1, 1, R,    1, 0, 6, 0,  0, 0, 0, 0, 0, 3, 0, 0, 1);
    addVec(1, 1, ADDI, 5, 0, 0, 0,  0, 0, 0, 0, 0, 2, 0, 0, 1);
    addVec(1, 1, R,    0, 0, 6, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1);
    addVec(1, 1, LW,   0, 7, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1);
    addVec(1, 1, R,    7, 6, 8, 1,  0, 0, 0, 1, 1, 0, 2, 0, 1);
    addVec(1, 0, R,    0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1);
    addVec(1, 1, J,    0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 1);
    addVec(1, 1, R,    1, 1, 9, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1);
    addVec(1, 1, R,    9, 9, 10, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    addVec(1, 1, H,    0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1);
    addVec(1, 0, R,    0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0, 1);
    addVec(1, 0, R,    0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0, 1);
    addVec(1, 0, R,    0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0, 1);
    addVec(1, 0, R,    0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 1, 1);
    addVec(1, 1, J,    0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 1, 1);
    addVec(0, 1, J,    0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 0, R,    0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, LW,   0, 2, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, R,    2, 2, 3, 0,  1, 1, 1, 0, 0, 0, 0, 0, 0);
    addVec(0, 1, R,    2, 2, 3, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, R,    2, 2, 3, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, J,    0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0);
    addVec(1, 1, H,    0, 0, 0, 1,  0, 0, 0, 1, 1, 0, 0, 0, 0);
    addVec(1, 0, R,    0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rstn, vecs[i].valid, vecs[i].op, vecs[i].rs, vecs[i].rt,
                    vecs[i].rd, vecs[i].br);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      @(posedge clk);
      #1;
    end

    applyStimulus(0, 0, R, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    modelReset();
    hold = 0;
    op = R; rs = 0; rt = 0; rd = 0; valid = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        pick = $urandom_range(0, 15);
        case (pick)
          5, 6, 7: op = LW;
          8:       op = ADDI;
          9:       op = ANDI;
          10:      op = SW;
          11:      op = BEQ;
          12:      op = BNE;
          13:      op = J;
          14:      op = ($urandom_range(0, 9) == 0) ? H : R;
          default: op = R;
        endcase
        rs = 5'($urandom_range(0, 4));
        rt = 5'($urandom_range(0, 4));
        rd = 5'($urandom_range(0, 4));
        valid = ($urandom_range(0, 5) != 0);
      end
      rstn = ($urandom_range(0, 399) != 0);
      if (mHalted && $urandom_range(0, 7) == 0) rstn = 0;
      br = ($urandom_range(0, 9) == 0);
      applyStimulus(rstn, valid, op, rs, rt, rd, br);
      e = predict(rstn, valid, op, rs, rt, rd, br);
      checkOutput($sformatf("rand%0d", c), e);
      @(posedge clk);
      #1;
      commit();
      hold = pStalled && !pReset;
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
